// File: rtl/icache_fetch_pkg.sv
// Shared widths, controller port encodings and fetch FSM states for the instruction cache.
package icache_fetch_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  localparam logic [1:0] MEM_IDLE  = 2'b00;
  localparam logic [1:0] MEM_WRITE = 2'b01;
  localparam logic [1:0] MEM_READ  = 2'b10;
  localparam logic [1:0] LEN_WORD  = 2'b11;
  localparam logic [1:0] LEN_NONE  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

endpackage

// File: rtl/icache_fetch_if.sv
// IF-stage request/response and memory-controller port 0 signals of the instruction cache.
interface icache_fetch_if #(
  parameter int ADDR_W = 32
);
  logic              rdy;
  logic              flush;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_valid;
  logic [31:0]       if_inst;
  logic [1:0]        mem_rw_flag;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        mem_len;
  logic              mem_busy;
  logic              mem_done;
  logic [31:0]       mem_data;

  modport master (
    output rdy, flush, if_req, if_addr, mem_busy, mem_done, mem_data,
    input  if_valid, if_inst, mem_rw_flag, mem_addr, mem_len
  );

  modport slave (
    input  rdy, flush, if_req, if_addr, mem_busy, mem_done, mem_data,
    output if_valid, if_inst, mem_rw_flag, mem_addr, mem_len
  );
endinterface

// File: rtl/icache_array.sv
// Direct-mapped valid/tag/data store: combinational read, clocked write, one-edge flush of all valid bits.
module icache_array #(
  parameter int INDEX_BITS = 7,
  parameter int TAG_W      = 23,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INDEX_BITS-1:0] i_rd_idx,
  output logic                  o_rd_vld,
  output logic [TAG_W-1:0]      o_rd_tag,
  output logic [DATA_W-1:0]     o_rd_dat,
  input  logic                  i_wr_en,
  input  logic [INDEX_BITS-1:0] i_wr_idx,
  input  logic [TAG_W-1:0]      i_wr_tag,
  input  logic [DATA_W-1:0]     i_wr_dat,
  input  logic                  i_flush
);
  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [DATA_W-1:0] r_data [LINES];

  assign o_rd_vld = r_valid[i_rd_idx];
  assign o_rd_tag = r_tag[i_rd_idx];
  assign o_rd_dat = r_data[i_rd_idx];

  // Flush wins over a same-edge install so a discarded fill never becomes visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (i_flush) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en && !i_flush) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_dat;
    end
  end

endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped word instruction cache: 1-cycle hit, miss issues a single one-cycle read on port 0.
module icache_fetch
  import icache_fetch_pkg::*;
#(
  parameter int INDEX_BITS = 7,
  parameter int ADDR_W     = 32
) (
  input logic           clk,
  input logic           rst_n,
  icache_fetch_if.slave bus
);
  localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

  state_e                r_state;
  state_e                w_state_nxt;
  logic                  r_if_valid, w_if_valid_nxt;
  logic [DATA_WIDTH-1:0] r_if_inst, w_if_inst_nxt;
  logic [1:0]            r_mem_rw_flag, w_rw_nxt;
  logic [ADDR_W-1:0]     r_mem_addr, w_addr_nxt;
  logic [1:0]            r_mem_len, w_len_nxt;
  logic                  r_served, w_served_nxt;
  logic [ADDR_W-3:0]     r_served_word, w_sword_nxt;
  logic                  r_discard, w_discard_nxt;

  logic [INDEX_BITS-1:0] w_idx;
  logic [TAG_W-1:0]      w_tag;
  logic [ADDR_W-3:0]     w_word;
  logic                  w_rd_vld;
  logic [TAG_W-1:0]      w_rd_tag;
  logic [DATA_WIDTH-1:0] w_rd_dat;
  logic                  w_hit;
  logic                  w_fresh;
  logic                  w_wr_en;
  logic                  w_unused;

  assign w_idx    = bus.if_addr[INDEX_BITS+1:2];
  assign w_tag    = bus.if_addr[ADDR_W-1:INDEX_BITS+2];
  assign w_word   = bus.if_addr[ADDR_W-1:2];
  assign w_hit    = w_rd_vld && (w_rd_tag == w_tag);
  assign w_fresh  = !(r_served && (r_served_word == w_word));
  assign w_unused = ^{bus.mem_busy, bus.if_addr[1:0]};

  icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_W      (TAG_W),
    .DATA_W     (DATA_WIDTH)
  ) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_rd_idx (w_idx),
    .o_rd_vld (w_rd_vld),
    .o_rd_tag (w_rd_tag),
    .o_rd_dat (w_rd_dat),
    .i_wr_en  (bus.rdy && w_wr_en),
    .i_wr_idx (r_mem_addr[INDEX_BITS+1:2]),
    .i_wr_tag (r_mem_addr[ADDR_W-1:INDEX_BITS+2]),
    .i_wr_dat (bus.mem_data),
    .i_flush  (bus.rdy && bus.flush)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else if (bus.rdy) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_if_valid_nxt = 1'b0;
    w_if_inst_nxt  = r_if_inst;
    w_rw_nxt       = r_mem_rw_flag;
    w_addr_nxt     = r_mem_addr;
    w_len_nxt      = r_mem_len;
    w_served_nxt   = r_served && bus.if_req;
    w_sword_nxt    = r_served_word;
    w_discard_nxt  = r_discard;
    w_wr_en        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.if_req && w_fresh && !bus.flush) begin
          if (w_hit) begin
            w_if_valid_nxt = 1'b1;
            w_if_inst_nxt  = w_rd_dat;
            w_served_nxt   = 1'b1;
            w_sword_nxt    = w_word;
          end else begin
            w_state_nxt   = ST_REQ;
            w_rw_nxt      = MEM_READ;
            w_addr_nxt    = {w_word, 2'b00};
            w_len_nxt     = LEN_WORD;
            w_discard_nxt = 1'b0;
          end
        end
      end
      // The controller samples on the opposite edge; a second flag cycle would fetch twice.
      ST_REQ: begin
        w_state_nxt = ST_WAIT;
        w_rw_nxt    = MEM_IDLE;
        w_len_nxt   = LEN_NONE;
        if (bus.flush) w_discard_nxt = 1'b1;
      end
      ST_WAIT: begin
        if (bus.flush) w_discard_nxt = 1'b1;
        if (bus.mem_done) begin
          if (r_discard || bus.flush) begin
            w_state_nxt   = ST_IDLE;
            w_discard_nxt = 1'b0;
          end else begin
            w_wr_en        = 1'b1;
            w_if_inst_nxt  = bus.mem_data;
            w_if_valid_nxt = 1'b1;
            w_state_nxt    = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        w_state_nxt  = ST_IDLE;
        w_served_nxt = bus.if_req;
        w_sword_nxt  = r_mem_addr[ADDR_W-1:2];
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_valid    <= 1'b0;
      r_if_inst     <= '0;
      r_mem_rw_flag <= MEM_IDLE;
      r_mem_addr    <= '0;
      r_mem_len     <= LEN_NONE;
      r_served      <= 1'b0;
      r_served_word <= '0;
      r_discard     <= 1'b0;
    end else if (bus.rdy) begin
      r_if_valid    <= w_if_valid_nxt;
      r_if_inst     <= w_if_inst_nxt;
      r_mem_rw_flag <= w_rw_nxt;
      r_mem_addr    <= w_addr_nxt;
      r_mem_len     <= w_len_nxt;
      r_served      <= w_served_nxt;
      r_served_word <= w_sword_nxt;
      r_discard     <= w_discard_nxt;
    end
  end

  assign bus.if_valid    = r_if_valid;
  assign bus.if_inst     = r_if_inst;
  assign bus.mem_rw_flag = r_mem_rw_flag;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_len     = r_mem_len;

endmodule

// File: tb/tb_icache_fetch.sv
// Directed plus randomized fetches against a behavioural direct-mapped cache model and memory image.
module tb_icache_fetch;
  import icache_fetch_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  icache_fetch_if #(.ADDR_W(32)) ifc ();

  icache_fetch #(.INDEX_BITS(7), .ADDR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one word per line, indexed by word address modulo 128.
  bit          m_vld [128];
  logic [22:0] m_tag [128];
  logic [31:0] m_dat [128];
  logic [31:0] mem_img [logic [31:0]];

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    logic [31:0] k;
    k = {a[31:2], 2'b00};
    if (mem_img.exists(k)) return mem_img[k];
    return (k * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    int idx;
    idx = int'(a[8:2]);
    return m_vld[idx] && (m_tag[idx] == a[31:9]);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 128; i++) m_vld[i] = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One fetch with a memory responder: done arrives `delay` cycles after the REQ cycle is seen.
  task automatic fetch(input logic [31:0] addr, input int delay, input int hold);
    bit          exp_miss;
    int          nreq, nval, vcyc, cd, idx;
    logic [31:0] got, exp_dat;
    exp_miss = !model_hit(addr);
    idx      = int'(addr[8:2]);
    exp_dat  = exp_miss ? mem_val(addr) : m_dat[idx];
    ifc.if_req  = 1'b1;
    ifc.if_addr = addr;
    nreq = 0; nval = 0; vcyc = -1; cd = -1; got = '0;
    for (int cyc = 0; cyc < 40 && nval == 0; cyc++) begin
      @(negedge clk);
      ifc.mem_done = 1'b0;
      ifc.mem_data = $urandom;
      if (ifc.mem_rw_flag == MEM_READ) begin
        nreq++;
        check("req_addr", ifc.mem_addr, {addr[31:2], 2'b00});
        check("req_len", 32'(ifc.mem_len), 32'(LEN_WORD));
        cd = delay;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          ifc.mem_done = 1'b1;
          ifc.mem_data = mem_val(addr);
        end
      end
      ifc.mem_busy = (cd > 0);
      if (ifc.if_valid) begin
        nval++;
        got  = ifc.if_inst;
        vcyc = cyc;
      end
    end
    check("req_count", nreq, exp_miss ? 1 : 0);
    check("valid_count", nval, 1);
    check("inst", got, exp_dat);
    check("latency", vcyc, exp_miss ? delay + 1 : 0);
    if (exp_miss) begin
      m_vld[idx] = 1'b1;
      m_tag[idx] = addr[31:9];
      m_dat[idx] = exp_dat;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      ifc.mem_done = 1'b0;
      check("held_no_valid", 32'(ifc.if_valid), 0);
      check("held_no_req", 32'(ifc.mem_rw_flag), 32'(MEM_IDLE));
    end
    @(negedge clk);
    ifc.mem_done = 1'b0;
    if (hold == 0) check("single_pulse", 32'(ifc.if_valid), 0);
    ifc.if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, 32'(ifc.if_valid), 0);
    check({tag, "_inst"}, ifc.if_inst, 0);
    check({tag, "_rw"}, 32'(ifc.mem_rw_flag), 0);
    check({tag, "_addr"}, ifc.mem_addr, 0);
    check({tag, "_len"}, 32'(ifc.mem_len), 0);
  endtask

  initial begin
    logic [31:0] a;
    checks = 0;
    errors = 0;
    ifc.rdy = 1'b1; ifc.flush = 1'b0; ifc.if_req = 1'b0; ifc.if_addr = '0;
    ifc.mem_busy = 1'b0; ifc.mem_done = 1'b0; ifc.mem_data = '0;
    model_clear();
    mem_img[32'h0000_0104] = 32'hDEAD_BEEF;
    mem_img[32'h0000_0200] = 32'h1234_5678;
    rst_n = 1'b0;
    #3;
    check_outputs_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Cold miss, hit after fill, then a same-index conflict evicting 0x104.
    fetch(32'h0000_0104, 3, 0);
    fetch(32'h0000_0104, 1, 2);
    fetch(32'h0000_0304, 2, 0);
    fetch(32'h0000_0104, 1, 0);

    // Flush while waiting: the fill is dropped and the held request misses again.
    ifc.if_req = 1'b1; ifc.if_addr = 32'h0000_0200;
    @(negedge clk);
    check("fw_req", 32'(ifc.mem_rw_flag), 32'(MEM_READ));
    @(negedge clk);
    ifc.flush = 1'b1;
    @(negedge clk);
    ifc.flush = 1'b0;
    model_clear();
    @(negedge clk);
    ifc.mem_done = 1'b1; ifc.mem_data = 32'h1234_5678;
    @(negedge clk);
    ifc.mem_done = 1'b0;
    check("fw_no_valid", 32'(ifc.if_valid), 0);
    fetch(32'h0000_0200, 2, 0);

    // rdy low during the REQ cycle holds the flag; one active cycle later the read is in WAIT.
    a = 32'h0000_0400;
    ifc.if_req = 1'b1; ifc.if_addr = a;
    @(negedge clk);
    check("rdy_req", 32'(ifc.mem_rw_flag), 32'(MEM_READ));
    ifc.rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rdy_hold_rw", 32'(ifc.mem_rw_flag), 32'(MEM_READ));
    end
    ifc.rdy = 1'b1;
    @(negedge clk);
    check("rdy_wait_rw", 32'(ifc.mem_rw_flag), 32'(MEM_IDLE));
    check("rdy_wait_valid", 32'(ifc.if_valid), 0);
    ifc.mem_done = 1'b1; ifc.mem_data = mem_val(a);
    @(negedge clk);
    ifc.mem_done = 1'b0;
    check("rdy_valid", 32'(ifc.if_valid), 1);
    check("rdy_inst", ifc.if_inst, mem_val(a));
    m_vld[0] = 1'b1; m_tag[0] = a[31:9]; m_dat[0] = mem_val(a);
    ifc.if_req = 1'b0;
    @(negedge clk);

    // Asynchronous reset while waiting; a late done is ignored and the cache is cold again.
    ifc.if_req = 1'b1; ifc.if_addr = 32'h0000_0500;
    @(negedge clk);
    check("ar_req", 32'(ifc.mem_rw_flag), 32'(MEM_READ));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("async_rst");
    ifc.if_req = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ifc.mem_done = 1'b1; ifc.mem_data = 32'hBAD0_BAD0;
    @(negedge clk);
    ifc.mem_done = 1'b0;
    check("ar_stray_valid0", 32'(ifc.if_valid), 0);
    @(negedge clk);
    check("ar_stray_valid1", 32'(ifc.if_valid), 0);
    fetch(32'h0000_0104, 2, 0);

    // Random traffic over a few indices (incl. the top line) and tags, with idle flushes.
    for (int n = 0; n < 60; n++) begin
      logic [6:0] idx;
      idx = ($urandom_range(0, 8) == 8) ? 7'd127 : 7'($urandom_range(0, 7));
      a = {23'($urandom_range(0, 3)), idx, 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 9) == 0) begin
        ifc.flush = 1'b1;
        @(negedge clk);
        ifc.flush = 1'b0;
        model_clear();
        @(negedge clk);
      end
      fetch(a, int'($urandom_range(1, 4)), int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
